// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the LC-3b two-way set-associative cache.
// Serves hits from IDLE and runs the writeback / line-fill sequence on a miss.
// Optional performance counters are enabled by defining CACHE_PERF_CTR_EN.
module cache_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  input  logic        hit0,
  input  logic        hit1,
  input  logic        lru,
  input  logic        dirty0,
  input  logic        dirty1,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp,
  output logic        pmem_addr_sel,
  output logic        data_in_sel,
  output logic        wb_way,
  output logic        load_data0,
  output logic        load_data1,
  output logic        load_tag0,
  output logic        load_tag1,
  output logic        load_valid0,
  output logic        load_valid1,
  output logic        load_dirty0,
  output logic        load_dirty1,
  output logic        dirty_in,
  output logic        load_lru,
  output logic        lru_in
`ifdef CACHE_PERF_CTR_EN
  ,
  input  logic        ctr_clr,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic [15:0] wb_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  logic   refill_q, refill_d;
  logic   miss_evt, wb_evt;
  logic   req, hit, hit_way, victim_dirty;

  assign req          = mem_read | mem_write;
  assign hit          = hit0 | hit1;
  assign hit_way      = ~hit0;               // way0 wins when both ways flag a hit
  assign victim_dirty = lru ? dirty1 : dirty0;

  // State, victim way and refill flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
    end
  end

  // Next-state and outputs; everything is forced low while reset is held
  // so an in-flight pmem request is dropped in the same cycle.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    refill_d      = refill_q;
    miss_evt      = 1'b0;
    wb_evt        = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    wb_way        = 1'b0;
    load_data0    = 1'b0;
    load_data1    = 1'b0;
    load_tag0     = 1'b0;
    load_tag1     = 1'b0;
    load_valid0   = 1'b0;
    load_valid1   = 1'b0;
    load_dirty0   = 1'b0;
    load_dirty1   = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = ~hit_way;
            refill_d = 1'b0;
            if (mem_write) begin
              dirty_in    = 1'b1;
              load_data0  = ~hit_way;
              load_data1  = hit_way;
              load_dirty0 = ~hit_way;
              load_dirty1 = hit_way;
            end
          end else if (req) begin
            victim_d = lru;
            refill_d = 1'b1;
            miss_evt = 1'b1;
            state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
          end else begin
            refill_d = 1'b0;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          wb_way        = victim_q;
          if (pmem_resp) begin
            wb_evt  = 1'b1;
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            data_in_sel = 1'b1;
            load_data0  = ~victim_q;
            load_data1  = victim_q;
            load_tag0   = ~victim_q;
            load_tag1   = victim_q;
            load_valid0 = ~victim_q;
            load_valid1 = victim_q;
            load_dirty0 = ~victim_q;
            load_dirty1 = victim_q;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CTR_EN
  logic [15:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic        hit_evt;

  // The re-compare hit that closes a miss is not a real hit
  assign hit_evt = mem_resp & ~refill_q;

  // Saturating counters; clear wins over any increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (ctr_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_evt  && hit_cnt_q  != 16'hFFFF) hit_cnt_q  <= hit_cnt_q  + 16'd1;
      if (miss_evt && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      if (wb_evt   && wb_cnt_q   != 16'hFFFF) wb_cnt_q   <= wb_cnt_q   + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control; counter checks only when CACHE_PERF_CTR_EN is defined.
module tb_cache_control;
  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, hit0, hit1, lru, dirty0, dirty1, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, wb_way;
  logic load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1;
  logic load_dirty0, load_dirty1, dirty_in, load_lru, lru_in;
`ifdef CACHE_PERF_CTR_EN
  logic ctr_clr;
  logic [15:0] hit_count, miss_count, wb_count;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [16:0] RESP = 17'h10000, PRD = 17'h08000, PWR = 17'h04000,
                          ASEL = 17'h02000, DSEL = 17'h01000, WBW = 17'h00800,
                          LD0  = 17'h00400, LD1 = 17'h00200, LT0 = 17'h00100,
                          LT1  = 17'h00080, LV0 = 17'h00040, LV1 = 17'h00020,
                          LY0  = 17'h00010, LY1 = 17'h00008, DIN = 17'h00004,
                          LLRU = 17'h00002, LRUI = 17'h00001;

  logic [16:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, wb_way,
                 load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1,
                 load_dirty0, load_dirty1, dirty_in, load_lru, lru_in};

  cache_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit0(hit0), .hit1(hit1), .lru(lru),
    .dirty0(dirty0), .dirty1(dirty1), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel),
    .wb_way(wb_way), .load_data0(load_data0), .load_data1(load_data1),
    .load_tag0(load_tag0), .load_tag1(load_tag1), .load_valid0(load_valid0),
    .load_valid1(load_valid1), .load_dirty0(load_dirty0), .load_dirty1(load_dirty1),
    .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in)
`ifdef CACHE_PERF_CTR_EN
    , .ctr_clr(ctr_clr), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic h0, input logic h1,
                     input logic l, input logic d0, input logic d1);
    mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1; lru = l; dirty0 = d0; dirty1 = d1;
  endtask

`ifdef CACHE_PERF_CTR_EN
  task automatic chk_ctr(input string tag, input int h, input int m, input int w);
    chk({tag, "_hit"},  {16'd0, hit_count},  h[31:0]);
    chk({tag, "_miss"}, {16'd0, miss_count}, m[31:0]);
    chk({tag, "_wb"},   {16'd0, wb_count},   w[31:0]);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pmem_resp = 1'b0;
`ifdef CACHE_PERF_CTR_EN
    ctr_clr = 1'b0;
`endif
    // request with a hit held during reset must not leak out
    cpu(1, 0, 0, 1, 1, 0, 0);
    #12;
    chk("rst_outs", {15'd0, outs}, 32'd0);
`ifdef CACHE_PERF_CTR_EN
    chk_ctr("rst", 0, 0, 0);
`endif
    tick();
    rst_n = 1'b1;
    #2;
    // read hit way1: lru_in points at way0
    chk("rd_hit_w1", {15'd0, outs}, {15'd0, RESP | LLRU});
    tick();
    cpu(0, 0, 0, 0, 0, 0, 0);
`ifdef CACHE_PERF_CTR_EN
    chk_ctr("rd_hit", 1, 0, 0);
`endif

    // write hit, both flags set: way0 has priority
    cpu(0, 1, 1, 1, 0, 0, 0);
    #2;
    chk("wr_hit_w0", {15'd0, outs}, {15'd0, RESP | LD0 | LY0 | DIN | LLRU | LRUI});
    tick();
    cpu(0, 0, 0, 0, 0, 0, 0);

    // clean read miss, victim way0 (dirty1 set but not the victim)
    cpu(1, 0, 0, 0, 0, 0, 1);
    #2;
    chk("cmiss_idle", {15'd0, outs}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("cmiss_alloc%0d", i), {15'd0, outs}, {15'd0, PRD});
      tick();
    end
    pmem_resp = 1'b1;
    #2;
    chk("cmiss_fill", {15'd0, outs}, {15'd0, PRD | DSEL | LD0 | LT0 | LV0 | LY0});
    tick();
    pmem_resp = 1'b0;
    hit0 = 1'b1;
    #2;
    chk("cmiss_resp", {15'd0, outs}, {15'd0, RESP | LLRU | LRUI});
    tick();
    cpu(0, 0, 0, 0, 0, 0, 0);
`ifdef CACHE_PERF_CTR_EN
    chk_ctr("cmiss", 2, 1, 0);
`endif

    // dirty write miss, victim way1; lru changes mid-miss but victim is latched
    cpu(0, 1, 0, 0, 1, 0, 1);
    #2;
    chk("dmiss_idle", {15'd0, outs}, 32'd0);
    tick();
    lru = 1'b0;
    #2;
    chk("dmiss_wb0", {15'd0, outs}, {15'd0, PWR | ASEL | WBW});
    tick();
    pmem_resp = 1'b1;
    #2;
    chk("dmiss_wb1", {15'd0, outs}, {15'd0, PWR | ASEL | WBW});
    tick();
    pmem_resp = 1'b0;
    #2;
    chk("dmiss_alloc", {15'd0, outs}, {15'd0, PRD});
    tick();
    pmem_resp = 1'b1;
    #2;
    chk("dmiss_fill", {15'd0, outs}, {15'd0, PRD | DSEL | LD1 | LT1 | LV1 | LY1});
    tick();
    pmem_resp = 1'b0;
    hit1 = 1'b1;
    #2;
    chk("dmiss_resp", {15'd0, outs}, {15'd0, RESP | LD1 | LY1 | DIN | LLRU});
    tick();
    cpu(0, 0, 0, 0, 0, 0, 0);
`ifdef CACHE_PERF_CTR_EN
    chk_ctr("dmiss", 2, 2, 1);
`endif

    // stray pmem_resp in IDLE does nothing
    pmem_resp = 1'b1;
    #2;
    chk("idle_presp0", {15'd0, outs}, 32'd0);
    tick();
    pmem_resp = 1'b0;
    #2;
    chk("idle_presp1", {15'd0, outs}, 32'd0);

    // request dropped mid-miss: fill completes, back to IDLE with no response
    cpu(1, 0, 0, 0, 0, 0, 0);
    tick();
    cpu(0, 0, 0, 0, 0, 0, 0);
    pmem_resp = 1'b1;
    #2;
    chk("drop_fill", {15'd0, outs}, {15'd0, PRD | DSEL | LD0 | LT0 | LV0 | LY0});
    tick();
    pmem_resp = 1'b0;
    #2;
    chk("drop_idle", {15'd0, outs}, 32'd0);
    tick();

    // reset pulsed in ALLOCATE
    cpu(1, 0, 0, 0, 0, 0, 0);
    tick();
    #2;
    chk("rstm_alloc", {15'd0, outs}, {15'd0, PRD});
    rst_n = 1'b0;
    #1;
    chk("rstm_drop", {15'd0, outs}, 32'd0);
`ifdef CACHE_PERF_CTR_EN
    chk_ctr("rstm", 0, 0, 0);
`endif
    tick();
    rst_n = 1'b1;
    cpu(1, 0, 1, 0, 1, 0, 0);
    #2;
    chk("rstm_idle_hit", {15'd0, outs}, {15'd0, RESP | LLRU | LRUI});
    tick();

`ifdef CACHE_PERF_CTR_EN
    // saturation and clear priority
    cpu(0, 0, 0, 0, 0, 0, 0);
    ctr_clr = 1'b1;
    tick();
    ctr_clr = 1'b0;
    chk_ctr("clr", 0, 0, 0);
    cpu(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_full", {16'd0, hit_count}, 32'h0000FFFF);
    tick();
    chk("sat_hold", {16'd0, hit_count}, 32'h0000FFFF);
    ctr_clr = 1'b1;
    tick();
    ctr_clr = 1'b0;
    chk("clr_prio", {16'd0, hit_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the LC-3b two-way set-associative cache. It consumes the per-way hit flags, the set's LRU bit and the dirty/valid bits from the cache datapath. It drives the datapath load enables and muxes, handles CPU requests, and runs physical-memory writeback and line-fill transactions. It sits between the CPU memory port, the cache datapath (tag compare, way arrays, LRU array) and physical memory.

## Interface
Parameters: none.

Ports:
- clk  in  1  cache clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  CPU request complete this cycle
- hit0, hit1  in  1  way hit flags for the addressed set
- lru  in  1  addressed set's LRU bit; 0 = way0 is least recent
- dirty0, dirty1  in  1  dirty bits of the addressed set
- pmem_read, pmem_write  out  1  physical-memory line read / write request
- pmem_resp  in  1  physical-memory transaction complete
- pmem_addr_sel  out  1  0 = CPU address, 1 = {victim tag, set index}
- data_in_sel  out  1  0 = CPU write data merged into line, 1 = pmem line
- wb_way  out  1  way whose line drives pmem write data
- load_data0/1, load_tag0/1, load_valid0/1, load_dirty0/1  out  1  per-way array write enables
- dirty_in  out  1  value written to dirty arrays
- load_lru, lru_in  out  1  LRU write enable / value
- ctr_clr  in  1  clears performance counters (only with CACHE_PERF_CTR_EN)
- hit_count, miss_count, wb_count  out  16  performance counters (only with CACHE_PERF_CTR_EN)

## Operation
- States: IDLE, WRITEBACK, ALLOCATE. All outputs are combinational from the state and inputs. All outputs are 0 unless listed.
- A request is active when mem_read or mem_write is high. If both are high, the request is treated as a write.
- Hit way: way0 if hit0=1; otherwise way1 if hit1=1. If both flags are high, way0 takes priority.
- IDLE, request active, hit:
  - Assert mem_resp and load_lru.
  - lru_in = ~hit_way.
  - On a write, also assert load_data[hit_way] and load_dirty[hit_way], with dirty_in=1 and data_in_sel=0.
  - Stay in IDLE.
- IDLE, request active, no hit:
  - Register victim = lru.
  - Go to WRITEBACK if dirty[lru]=1; otherwise go to ALLOCATE.
- IDLE, no request: idle.
- WRITEBACK:
  - Assert pmem_write and pmem_addr_sel=1; wb_way = victim.
  - On pmem_resp, go to ALLOCATE. Otherwise hold.
- ALLOCATE:
  - Assert pmem_read and pmem_addr_sel=0.
  - On pmem_resp, assert load_data/tag/valid/dirty[victim] with data_in_sel=1 and dirty_in=0, then go to IDLE.
  - On return to IDLE, the re-compare hits and completes the request.
- If the CPU drops its request mid-miss, the pmem transaction still completes, followed by a return to IDLE with no mem_resp.
- Register refill = 1 on each miss transition. Clear it when mem_resp asserts or when IDLE is reached with no request.

## Timing
- Reset (asynchronous, rst_n=0):
  - State = IDLE, victim = 0, refill = 0, counters = 0.
  - All outputs are 0 during and after reset.
  - Reset mid-WRITEBACK or mid-ALLOCATE abandons the pmem request in the same cycle.
- Hit latency: mem_resp in the same cycle the request is first seen in IDLE.
- Clean miss: IDLE(miss) → ALLOCATE at edge+1. pmem_resp in cycle k gives mem_resp in cycle k+1.
- Dirty miss: WRITEBACK until pmem_resp, then ALLOCATE from the next edge; same fill rule.
- pmem_read and pmem_write are held steady until pmem_resp and are never asserted together.
- A pmem_resp while in IDLE is ignored.

## Configuration
- CACHE_PERF_CTR_EN defined:
  - hit_count increments on mem_resp when refill = 0.
  - miss_count increments on each IDLE → WRITEBACK/ALLOCATE transition.
  - wb_count increments on WRITEBACK exit via pmem_resp.
  - All counters are 16-bit and saturate at 0xFFFF.
  - ctr_clr synchronously zeroes all counters and takes priority over increments.
- Not defined: the counters, ctr_clr and the counter ports are absent; FSM behaviour is identical.

## Test plan
- Read hit, way1 (hit1=1, lru=1, mem_read=1): mem_resp and load_lru with lru_in=0 in the same cycle; no pmem activity; hit_count=1.
- Write hit, way0: load_data0, load_dirty0, dirty_in=1, data_in_sel=0 and mem_resp in one cycle; lru_in=1.
- Clean read miss (lru=0, dirty0=0), pmem_resp after 5 cycles:
  - ALLOCATE for 5 cycles with pmem_read=1.
  - Fill strobes to way0 with data_in_sel=1.
  - mem_resp on the next cycle.
  - miss_count=1, hit_count=0.
- Dirty miss (lru=1, dirty1=1):
  - WRITEBACK with pmem_write=1, pmem_addr_sel=1, wb_way=1 until pmem_resp.
  - Then ALLOCATE and fill way1.
  - wb_count=1.
- rst_n pulsed low mid-ALLOCATE: pmem_read drops immediately; IDLE with all outputs 0; counters 0.
- Counter saturation: preload via 65535 hits, one more hit → hit_count stays 0xFFFF; ctr_clr in the same cycle as a hit → 0.
